// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op and state encodings for the EX-stage mul/div unit
package mips_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } muldivOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldivState_t;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, read as unsigned
  function automatic logic [31:0] absVal(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (mult) or restoring subtract-shift (div) iteration
module muldiv_step (
  input  logic [63:0] accIn,
  input  logic [31:0] operand,
  input  logic        isDiv,
  output logic [63:0] accOut
);

  logic [32:0] sum;
  logic [32:0] partial;
  logic [31:0] rem;
  logic        fits;

  // Mult: add multiplicand into the upper half when the multiplier LSB is set, then shift
  // right keeping the carry. Div: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits, shifting the quotient bit in at the bottom.
  always_comb begin
    sum     = {1'b0, accIn[63:32]} + (accIn[0] ? {1'b0, operand} : 33'd0);
    partial = accIn[63:31];
    fits    = partial >= {1'b0, operand};
    rem     = partial[31:0] - operand;
    accOut  = {sum, accIn[31:1]};
    if (isDiv) begin
      if (fits) begin
        accOut = {rem, accIn[30:0], 1'b1};
      end else begin
        accOut = {partial[31:0], accIn[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative HI/LO multiply/divide unit for the EX stage
module ex_muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        rd_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  muldivState_t state, nextState;
  logic [63:0]  acc, accStep, product;
  logic [31:0]  operand, hiReg, loReg, fixHi, fixLo, quotient, remainder;
  logic [4:0]   counter;
  logic         isDiv, negA, negB, divZero, doneReg;
  logic         mdStart, signedOp, divOp;

  muldiv_step uStep (
    .accIn  (acc),
    .operand(operand),
    .isDiv  (isDiv),
    .accOut (accStep)
  );

  // Decode the incoming op into launch/sign/mode qualifiers
  always_comb begin
    mdStart  = start && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
    signedOp = (op == OP_MULT) || (op == OP_DIV);
    divOp    = (op == OP_DIV) || (op == OP_DIVU);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next state: launch from IDLE, 32 RUN steps, one FIX cycle; flush always returns to IDLE
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (mdStart) nextState = ST_RUN;
      ST_RUN:  if (counter == 5'd31) nextState = ST_FIX;
      ST_FIX:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    if (flush) nextState = ST_IDLE;
  end

  // Sign correction of the unsigned result; remainder follows the dividend sign
  always_comb begin
    product   = (negA ^ negB) ? (~acc + 64'd1) : acc;
    quotient  = (negA ^ negB) ? (~acc[31:0] + 32'd1) : acc[31:0];
    remainder = negA ? (~acc[63:32] + 32'd1) : acc[63:32];
    fixHi     = product[63:32];
    fixLo     = product[31:0];
    if (isDiv) begin
      fixHi = remainder;
      fixLo = divZero ? 32'hFFFF_FFFF : quotient;
    end
  end

  // Operand capture, iteration, HI/LO writeback and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      operand <= '0;
      counter <= '0;
      isDiv   <= 1'b0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (flush) begin
        counter <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mdStart) begin
              acc     <= {32'd0, signedOp ? absVal(opA) : opA};
              operand <= signedOp ? absVal(opB) : opB;
              negA    <= signedOp & opA[31];
              negB    <= signedOp & opB[31];
              isDiv   <= divOp;
              divZero <= (opB == 32'd0);
              counter <= '0;
            end else if (start && op == OP_MTHI) begin
              hiReg <= opA;
            end else if (start && op == OP_MTLO) begin
              loReg <= opA;
            end
          end
          ST_RUN: begin
            acc     <= accStep;
            counter <= counter + 5'd1;
          end
          ST_FIX: begin
            hiReg   <= fixHi;
            loReg   <= fixLo;
            doneReg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign hi    = hiReg;
  assign lo    = loReg;
  assign done  = doneReg;
  assign busy  = (state != ST_IDLE);
  assign stall = busy & (start | rd_hilo);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv against an arithmetic reference
module tb_ex_muldiv;

  localparam logic [2:0] C_MULT = 3'd1, C_MULTU = 3'd2, C_DIV = 3'd3, C_DIVU = 3'd4;
  localparam logic [2:0] C_MTHI = 3'd5, C_MTLO = 3'd6;

  logic        clk = 1'b0;
  logic        reset, flush, start, rd_hilo;
  logic [2:0]  op;
  logic [31:0] opA, opB, hi, lo;
  logic        busy, stall, done;

  int tests = 0;
  int failed = 0;
  logic [63:0] expQ[$];

  ex_muldiv dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
    .opA(opA), .opB(opB), .rd_hilo(rd_hilo), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      C_MULT:  begin q = sa * sb; return q; end
      C_MULTU: return ua * ub;
      C_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      C_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        ua = {32'd0, a} / ub;
        ub = {32'd0, a} % ub;
        return {ub[31:0], ua[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      tests++;
      if (expQ.size() == 0) begin
        failed++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        if ({hi, lo} !== e) begin
          failed++;
          $display("FAIL result: got %h_%h expected %h_%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int rdAt, input bit interfere);
    int cyc, busyBad, stallBad;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    expQ.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cyc = 0; seen = 1'b0; busyBad = 0; stallBad = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); cyc++;
      #1;
      if (cyc == rdAt) rd_hilo = 1'b1;
      if (interfere && cyc == 3) begin
        start = 1'b1; op = C_DIVU; opA = $urandom; opB = $urandom;
      end
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (rdAt >= 0 || interfere) check("stall_at_done", stall, 0);
      end else begin
        if (busy !== 1'b1) busyBad++;
        if (rdAt >= 0 && cyc >= rdAt && stall !== 1'b1) stallBad++;
        if (interfere && cyc >= 3 && stall !== 1'b1) stallBad++;
      end
    end
    start = 1'b0; rd_hilo = 1'b0; op = 3'd0;
    check("op_completed", seen, 1);
    check("latency", cyc, 33);
    check("busy_during_run", busyBad, 0);
    if (rdAt >= 0 || interfere) check("stall_held", stallBad, 0);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic moveOp(input logic [2:0] o, input logic [31:0] v);
    logic [31:0] prevHi, prevLo;
    @(negedge clk);
    prevHi = hi; prevLo = lo;
    start = 1'b1; op = o; opA = v;
    #1;
    check("move_no_forward", {hi, lo}, {prevHi, prevLo});
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    if (o == C_MTHI) check("mthi", {hi, lo}, {v, prevLo});
    else             check("mtlo", {hi, lo}, {prevHi, v});
    check("move_no_busy_done", {busy, done}, 0);
  endtask

  // Launch an op that will be aborted; returns with the unit mid-RUN after n cycles
  task automatic launchAbort(input int n);
    @(negedge clk);
    start = 1'b1; op = C_MULT; opA = 32'h1234_5678; opB = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic countDones(input string name, input int n);
    int d;
    d = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) d++;
    end
    check(name, d, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b1; start = 1'b1; op = C_MTHI; opA = 32'hFFFF; opB = 0; rd_hilo = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 0);
    check("reset_busy_done_stall", {busy, done, stall}, 0);
    reset = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0; rd_hilo = 1'b0;

    moveOp(C_MTHI, 32'h0000_1234);
    moveOp(C_MTLO, 32'hCAFE_0001);

    runOp(C_MULT,  32'hFFFF_FFFE, 32'h0000_0003, -1, 1'b0);
    runOp(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    runOp(C_DIV,   32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
    runOp(C_DIVU,  32'h0000_0007, 32'h0000_0000, -1, 1'b1);
    runOp(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    runOp(C_DIV,   32'hFFFF_FFF0, 32'h0000_0000, -1, 1'b0);
    runOp(C_MULT,  32'h8000_0000, 32'h8000_0000, -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(1, 4));
      runOp(o, pick(), pick(), (i % 5 == 0) ? 7 : -1, 1'b0);
    end

    moveOp(C_MTHI, 32'h0000_AAAA);
    launchAbort(10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_hi_kept", hi, 32'h0000_AAAA);
    countDones("flush_no_done", 40);

    launchAbort(15);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_hilo", {hi, lo}, 0);
    check("midrun_reset_flags", {busy, done, stall}, 0);
    countDones("reset_no_done", 40);

    check("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
